// File: rtl/tug_pkg.sv
// Shared types and widths for the tug-of-war arena engine.
package tug_pkg;

    typedef enum logic [1:0] {PLAY, POINT, MATCH_OVER} arena_state_t;
    typedef enum logic [1:0] {NONE = 2'b00, LEFT = 2'b01, RIGHT = 2'b10} side_t;

    localparam int SCORE_W = 4;

endpackage

// File: rtl/tug_arena_press_detect.sv
// Button synchroniser followed by a rising-edge detector; yields one pulse per press.
module press_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], btn};
            prev <= sync[SYNC_STAGES-1];
        end
    end

    assign pulse = sync[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/tug_arena.sv
// Tug-of-war playfield: one-hot rope, two players, per-player scores, point/match hold.
module tug_arena
    import tug_pkg::*;
#(
    parameter int N_LIGHTS    = 9,
    parameter int WIN_SCORE   = 7,
    parameter int HOLD_CYCLES = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                left_btn,
    input  logic                right_btn,
    output logic [N_LIGHTS-1:0] lights,
    output logic [SCORE_W-1:0]  left_score,
    output logic [SCORE_W-1:0]  right_score,
    output logic                point_flag,
    output logic [1:0]          winner,
    output logic                match_over
);

    localparam int                   HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [SCORE_W-1:0]   WIN       = SCORE_W'(WIN_SCORE);
    localparam logic [N_LIGHTS-1:0]  CENTRE    = N_LIGHTS'(1) << ((N_LIGHTS - 1) / 2);

    logic         lp;
    logic         rp;
    logic         won;
    arena_state_t state;
    side_t        scorer;
    logic [HOLD_W-1:0] hold_cnt;

    press_detect #(.SYNC_STAGES(SYNC_STAGES)) u_left (
        .clk   (clk),
        .reset (reset),
        .btn   (left_btn),
        .pulse (lp)
    );

    press_detect #(.SYNC_STAGES(SYNC_STAGES)) u_right (
        .clk   (clk),
        .reset (reset),
        .btn   (right_btn),
        .pulse (rp)
    );

    // Score was already bumped on entry to POINT, so compare the stored value.
    assign won = (scorer == LEFT) ? (left_score == WIN) : (right_score == WIN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lights      <= CENTRE;
            left_score  <= '0;
            right_score <= '0;
            point_flag  <= 1'b0;
            winner      <= NONE;
            match_over  <= 1'b0;
            state       <= PLAY;
            scorer      <= NONE;
            hold_cnt    <= '0;
        end else begin
            case (state)
                PLAY: begin
                    if (lp && !rp) begin
                        if (lights[N_LIGHTS-1]) begin
                            if (left_score < WIN)
                                left_score <= left_score + SCORE_W'(1);
                            scorer     <= LEFT;
                            state      <= POINT;
                            point_flag <= 1'b1;
                            hold_cnt   <= '0;
                        end else begin
                            lights <= {lights[N_LIGHTS-2:0], 1'b0};
                        end
                    end else if (rp && !lp) begin
                        if (lights[0]) begin
                            if (right_score < WIN)
                                right_score <= right_score + SCORE_W'(1);
                            scorer     <= RIGHT;
                            state      <= POINT;
                            point_flag <= 1'b1;
                            hold_cnt   <= '0;
                        end else begin
                            lights <= {1'b0, lights[N_LIGHTS-1:1]};
                        end
                    end
                end
                POINT: begin
                    if (hold_cnt == HOLD_LAST) begin
                        point_flag <= 1'b0;
                        if (won) begin
                            state      <= MATCH_OVER;
                            match_over <= 1'b1;
                            winner     <= scorer;
                            lights     <= (scorer == LEFT) ? '1 : '0;
                        end else begin
                            state  <= PLAY;
                            lights <= CENTRE;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
